// File: rtl/sata_fis_packetizer_if.sv
// Beat stream from the packetizer to the link-layer framer.
// One beat moves on every clock where valid and ready are both high.
interface sata_fis_packetizer_if #(
    parameter int unsigned DW = 32
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/sata_fis_packetizer.sv
// DMA-write transmit stage: pops words from a first-word-fall-through FIFO and
// emits them as Data-FIS payload frames of at most 2^LGFIS dwords. Each frame
// is released by one DMA-Activate.
module sata_fis_packetizer #(
    parameter int unsigned DW    = 32,
    parameter int unsigned LGLEN = 20,
    parameter int unsigned LGFIS = 11
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [LGLEN-1:0]     i_len,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    input  logic                 i_dma_act,
    output logic                 o_fifo_rd,
    input  logic [DW-1:0]        i_fifo_data,
    input  logic                 i_fifo_empty,
    sata_fis_packetizer_if.master tx
);

    localparam int unsigned FisMax = 1 << LGFIS;

    typedef enum logic [1:0] {StIdle, StWaitAct, StXfer} state_t;

    state_t            state;
    logic [LGLEN-1:0]  remaining;
    logic [LGFIS:0]    frame_left;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [LGFIS:0]    act_len;
    logic              accept;

    assign tx.valid = out_valid;
    assign tx.data  = out_data;
    assign tx.last  = out_last;
    assign o_busy   = (state != StIdle);
    assign accept   = out_valid && tx.ready;

    // Pop whenever a frame has words left and the output register is free or draining.
    assign o_fifo_rd = (state == StXfer) && !i_fifo_empty && (frame_left != '0)
                     && (!out_valid || tx.ready);

    // Frame length granted by one DMA-Activate: min(remaining, 2^LGFIS).
    always_comb begin
        act_len = remaining[LGFIS:0];
        if (remaining >= LGLEN'(FisMax)) begin
            act_len = (LGFIS+1)'(FisMax);
        end
    end

    // Transfer FSM with registered stream outputs; abort overrides all but reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= StIdle;
            remaining  <= '0;
            frame_left <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (i_start) begin
                        if (i_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            remaining <= i_len;
                            state     <= StWaitAct;
                        end
                    end
                end
                StWaitAct: begin
                    if (i_dma_act) begin
                        frame_left <= act_len;
                        state      <= StXfer;
                    end
                end
                StXfer: begin
                    if (o_fifo_rd) begin
                        out_data   <= i_fifo_data;
                        out_valid  <= 1'b1;
                        out_last   <= (frame_left == (LGFIS+1)'(1));
                        frame_left <= frame_left - (LGFIS+1)'(1);
                        remaining  <= remaining - LGLEN'(1);
                    end else if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    // frame_left is zero once the last beat is pending, so no pop races it
                    if (accept && out_last) begin
                        if (remaining == '0) begin
                            o_done <= 1'b1;
                            state  <= StIdle;
                        end else begin
                            state <= StWaitAct;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
            if (i_abort) begin
                state     <= StIdle;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                o_done    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sata_fis_packetizer.sv
// Self-checking bench for sata_fis_packetizer: a FIFO model feeds the DUT, a
// cycle-level reference model predicts every output, and directed scenarios
// pin the model with hand-computed expectations.
module tb_sata_fis_packetizer;

    localparam int FisMax = 2048;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [19:0] i_len = '0;
    logic        i_abort = 1'b0;
    logic        i_dma_act = 1'b0;
    logic        o_busy, o_done, o_fifo_rd;
    logic [31:0] f_data = '0;
    logic        f_empty = 1'b1;

    sata_fis_packetizer_if #(.DW(32)) tx_if ();

    sata_fis_packetizer dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_abort     (i_abort),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .i_dma_act   (i_dma_act),
        .o_fifo_rd   (o_fifo_rd),
        .i_fifo_data (f_data),
        .i_fifo_empty(f_empty),
        .tx          (tx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment: FIFO contents and monitor logs.
    logic [31:0] fifo[$];
    logic [31:0] beats[$];
    logic        lasts[$];
    int          done_cnt = 0;
    int          pop_cnt = 0;
    logic        pop_pending = 1'b0;

    // Reference model: transfer phase, words left in transfer and frame, held beat.
    typedef enum int {PhIdle, PhWait, PhSend} phase_t;
    phase_t      m_phase = PhIdle;
    int          m_rem = 0;
    int          m_frame = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    logic        m_last = 1'b0;
    logic        m_done = 1'b0;
    logic        live = 1'b0;

    // The FIFO pops on the same edge the DUT captures the head word.
    always @(posedge clk) begin
        #1;
        if (pop_pending) void'(fifo.pop_front());
    end

    // Compare, monitor and advance the model once per cycle, mid-period.
    always @(negedge clk) begin
        logic exp_pop, acc, was_last;
        int   rem0, frame0;
        f_empty = (fifo.size() == 0);
        f_data  = f_empty ? 32'h0 : fifo[0];
        #1;
        exp_pop = (m_phase == PhSend) && !f_empty && (m_frame != 0) && (!m_valid || tx_if.ready);
        if (live) begin
            chk("busy", o_busy, m_phase != PhIdle);
            chk("done", o_done, m_done);
            chk("fifo_rd", o_fifo_rd, exp_pop);
            chk("valid", tx_if.valid, m_valid);
            if (m_valid) begin
                chk("data", tx_if.data, m_data);
                chk("last", tx_if.last, m_last);
            end
        end
        if (tx_if.valid && tx_if.ready) begin
            beats.push_back(tx_if.data);
            lasts.push_back(tx_if.last);
        end
        if (o_done) done_cnt++;
        if (o_fifo_rd) pop_cnt++;
        pop_pending = o_fifo_rd;

        acc      = m_valid && tx_if.ready;
        was_last = m_last;
        rem0     = m_rem;
        frame0   = m_frame;
        m_done   = 1'b0;
        if (i_reset) begin
            m_phase = PhIdle; m_rem = 0; m_frame = 0;
            m_valid = 1'b0; m_last = 1'b0; m_data = '0;
            live = 1'b1;
        end else if (i_abort) begin
            m_phase = PhIdle; m_valid = 1'b0; m_last = 1'b0;
        end else begin
            case (m_phase)
                PhIdle: if (i_start) begin
                    if (i_len == 0) m_done = 1'b1;
                    else begin m_rem = int'(i_len); m_phase = PhWait; end
                end
                PhWait: if (i_dma_act) begin
                    m_frame = (m_rem > FisMax) ? FisMax : m_rem;
                    m_phase = PhSend;
                end
                default: begin
                    if (exp_pop) begin
                        m_data = f_data; m_valid = 1'b1; m_last = (frame0 == 1);
                        m_frame = frame0 - 1; m_rem = rem0 - 1;
                    end else if (acc) begin
                        m_valid = 1'b0; m_last = 1'b0;
                    end
                    if (acc && was_last) begin
                        if (rem0 == 0) begin m_done = 1'b1; m_phase = PhIdle; end
                        else m_phase = PhWait;
                    end
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic start(input int len);
        i_len = 20'(len);
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic act();
        i_dma_act = 1'b1;
        cyc();
        i_dma_act = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin cyc(); n++; end
        chk(name, done_cnt != base, 1'b1);
    endtask

    task automatic wait_beats(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (beats.size() < target && n < budget) begin cyc(); n++; end
        chk(name, beats.size() >= target, 1'b1);
    endtask

    int          bb, bd, bp, len, pushed, n, nl;
    logic [31:0] w;
    logic [31:0] sent[$];

    initial begin
        tx_if.ready = 1'b1;
        cycles(3);
        i_reset = 1'b0;
        cyc();
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_rd", o_fifo_rd, 1'b0);
        chk("rst_valid", tx_if.valid, 1'b0);
        chk("rst_last", tx_if.last, 1'b0);

        // 1: four words, one frame
        for (int i = 0; i < 4; i++) fifo.push_back(32'hA0 + 32'(i));
        bb = beats.size(); bd = done_cnt; bp = pop_cnt;
        start(4);
        act();
        wait_done("t1_done_timeout", bd, 100);
        chk("t1_beats", beats.size() - bb, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", beats[bb+i], 32'hA0 + 32'(i));
            chk("t1_last", lasts[bb+i], i == 3);
        end
        chk("t1_pops", pop_cnt - bp, 4);
        cyc();
        chk("t1_done_once", done_cnt - bd, 1);

        // 2: 2050 words split into 2048 + 2
        for (int i = 0; i < 2050; i++) fifo.push_back(32'h1000 + 32'(i));
        bb = beats.size(); bd = done_cnt;
        start(2050);
        act();
        wait_beats("t2_frame1_timeout", bb + 2048, 3000);
        cycles(5);
        chk("t2_wait_valid", tx_if.valid, 1'b0);
        chk("t2_wait_busy", o_busy, 1'b1);
        chk("t2_frame1_len", beats.size() - bb, 2048);
        chk("t2_frame1_last", lasts[bb+2047], 1'b1);
        chk("t2_frame1_mid", lasts[bb+2046], 1'b0);
        act();
        wait_done("t2_done_timeout", bd, 100);
        chk("t2_total", beats.size() - bb, 2050);
        chk("t2_frame2_last", lasts[bb+2049], 1'b1);
        chk("t2_frame2_first", lasts[bb+2048], 1'b0);
        chk("t2_tail_data", beats[bb+2049], 32'h1000 + 32'd2049);

        // 3: downstream stall mid-frame
        for (int i = 0; i < 6; i++) fifo.push_back(32'hC0 + 32'(i));
        bb = beats.size(); bd = done_cnt;
        start(6);
        act();
        cycles(2);
        tx_if.ready = 1'b0;
        cyc();
        w = tx_if.data;
        cycles(2);
        chk("t3_stall_data", tx_if.data, w);
        chk("t3_stall_rd", o_fifo_rd, 1'b0);
        tx_if.ready = 1'b1;
        wait_done("t3_done_timeout", bd, 100);
        chk("t3_beats", beats.size() - bb, 6);
        for (int i = 0; i < 6; i++) chk("t3_order", beats[bb+i], 32'hC0 + 32'(i));

        // 4: FIFO runs dry after two words, refilled later
        fifo.push_back(32'hD0); fifo.push_back(32'hD1);
        bb = beats.size(); bd = done_cnt;
        start(5);
        act();
        cycles(12);
        chk("t4_dry_valid", tx_if.valid, 1'b0);
        for (int i = 2; i < 5; i++) fifo.push_back(32'hD0 + 32'(i));
        wait_done("t4_done_timeout", bd, 100);
        chk("t4_beats", beats.size() - bb, 5);
        nl = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_order", beats[bb+i], 32'hD0 + 32'(i));
            nl += int'(lasts[bb+i]);
        end
        chk("t4_one_last", nl, 1);

        // 5: abort after the third beat, then a fresh transfer
        for (int i = 0; i < 8; i++) fifo.push_back(32'hE0 + 32'(i));
        bb = beats.size(); bd = done_cnt;
        start(8);
        act();
        wait_beats("t5_beats_timeout", bb + 3, 100);
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        chk("t5_abort_valid", tx_if.valid, 1'b0);
        chk("t5_abort_busy", o_busy, 1'b0);
        cycles(4);
        chk("t5_no_done", done_cnt, bd);
        fifo.delete();
        cyc();
        fifo.push_back(32'hF0); fifo.push_back(32'hF1);
        bb = beats.size();
        start(2);
        act();
        wait_done("t5_restart_timeout", bd, 100);
        chk("t5_restart_beats", beats.size() - bb, 2);
        chk("t5_restart_data", beats[bb+1], 32'hF1);

        // 6: zero-length transfer, then reset mid-transfer
        bp = pop_cnt; bd = done_cnt;
        cyc();
        start(0);
        chk("t6_len0_done", o_done, 1'b1);
        chk("t6_len0_busy", o_busy, 1'b0);
        cyc();
        chk("t6_len0_pulse", o_done, 1'b0);
        chk("t6_len0_pops", pop_cnt - bp, 0);
        for (int i = 0; i < 4; i++) fifo.push_back(32'h55 + 32'(i));
        start(4);
        act();
        tx_if.ready = 1'b0;
        cycles(3);
        i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        chk("t6_rst_valid", tx_if.valid, 1'b0);
        chk("t6_rst_last", tx_if.last, 1'b0);
        chk("t6_rst_busy", o_busy, 1'b0);
        chk("t6_rst_done", o_done, 1'b0);
        chk("t6_rst_rd", o_fifo_rd, 1'b0);
        tx_if.ready = 1'b1;
        fifo.delete();
        cycles(2);

        // 7: randomized transfers with random ready, activates and FIFO refill
        for (int t = 0; t < 30; t++) begin
            len = int'($urandom_range(1, 40));
            bb = beats.size(); bd = done_cnt; pushed = 0; n = 0;
            sent.delete();
            start(len);
            while (done_cnt == bd && n < 3000) begin
                tx_if.ready = ($urandom_range(0, 3) != 0);
                i_dma_act = ($urandom_range(0, 2) == 0);
                if (pushed < len && $urandom_range(0, 1) == 1) begin
                    w = $urandom;
                    fifo.push_back(w);
                    sent.push_back(w);
                    pushed++;
                end
                cyc();
                n++;
            end
            i_dma_act = 1'b0;
            tx_if.ready = 1'b1;
            chk("rnd_done_timeout", done_cnt != bd, 1'b1);
            chk("rnd_beats", beats.size() - bb, len);
            for (int i = 0; i < len && bb + i < beats.size(); i++)
                chk("rnd_order", beats[bb+i], sent[i]);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
